// File: rtl/mac_array_seq.sv
// Instruction sequencer for the 2-D MAC tile array: drives a diagonal wavefront of 3-bit tile
// instructions for weight-stationary and output-stationary runs. Optional abort input under SEQ_ABORT_EN.
module mac_array_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [cnt_bw-1:0]   num_vec,
`ifdef SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic [3*row-1:0]    inst_w,
    output logic                buf_rd,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [cnt_bw-1:0] load_last  = cnt_bw'(col - 1);
    localparam logic [cnt_bw-1:0] drain_last = cnt_bw'(row + col - 2);

    state_t              state, state_n;
    logic [cnt_bw-1:0]   cnt, cnt_n;
    logic [cnt_bw-1:0]   nv_q, nv_n;
    logic                mode_q, mode_n;
    logic                abort_q, abort_n;
    logic [2:0]          base;

    function automatic logic [2:0] base_for(input state_t s, input logic m, input logic ab);
        case (s)
            LOAD:      return 3'b001;
            GAP, DONE: return {m, 2'b00};
            EXEC:      return m ? 3'b101 : 3'b010;
            DRAIN:     return ab ? 3'b000 : {m, m, 1'b0};
            default:   return 3'b000;
        endcase
    endfunction

    // Each counted state is entered with its last index and leaves when the down-count hits 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        nv_n    = nv_q;
        mode_n  = mode_q;
        abort_n = abort_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    nv_n    = num_vec;
                    abort_n = 1'b0;
                    if (!mode) begin
                        state_n = LOAD;
                        cnt_n   = load_last;
                    end else if (num_vec == '0) begin
                        state_n = DRAIN;
                        cnt_n   = drain_last;
                    end else begin
                        state_n = EXEC;
                        cnt_n   = num_vec - 1'b1;
                    end
                end
            end
            LOAD: begin
                if (cnt == '0) state_n = GAP;
                else           cnt_n   = cnt - 1'b1;
            end
            GAP: begin
                if (nv_q == '0) begin
                    state_n = DRAIN;
                    cnt_n   = drain_last;
                end else begin
                    state_n = EXEC;
                    cnt_n   = nv_q - 1'b1;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_n = DRAIN;
                    cnt_n   = drain_last;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == '0) state_n = DONE;
                else           cnt_n   = cnt - 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef SEQ_ABORT_EN
        if (abort && (state == LOAD || state == GAP || state == EXEC)) begin
            state_n = DRAIN;
            cnt_n   = drain_last;
            abort_n = 1'b1;
        end
`endif
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            nv_q    <= '0;
            mode_q  <= 1'b0;
            abort_q <= 1'b0;
            base    <= 3'b000;
            buf_rd  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            nv_q    <= nv_n;
            mode_q  <= mode_n;
            abort_q <= abort_n;
            base    <= base_for(state_n, mode_n, abort_n);
            buf_rd  <= (state_n == LOAD) || (state_n == EXEC);
            busy    <= (state_n != IDLE);
            done    <= (state_n == DONE);
        end
    end

    generate
        if (row > 1) begin : g_stagger
            // Lane r sits in tail[3(r-1)+:3]; keeps shifting in IDLE so the wavefront drains out.
            logic [3*(row-1)-1:0] tail;
            always_ff @(posedge clk) begin
                if (reset) begin
                    tail <= '0;
                end else begin
                    tail[2:0] <= base;
                    for (int r = 1; r < row - 1; r++) begin
                        tail[3*r +: 3] <= tail[3*(r-1) +: 3];
                    end
                end
            end
            assign inst_w = {tail, base};
        end else begin : g_single
            assign inst_w = base;
        end
    endgenerate

endmodule

// File: doc/mac_array_seq.md
Name: mac_array_seq

Overview:
- Instruction sequencer for the 2-D MAC tile array.
- Generates the 3-bit tile instruction (bit2 = mode, bit1 = execute/pass_psum, bit0 = kernel-load/accumulate) for each array row's west edge.
- Supports both weight-stationary (WS) and output-stationary (OS) runs.
- Row r receives the row-0 instruction delayed r cycles (diagonal wavefront). Also issues the read strobe for the activation/weight input buffer and a done pulse to the top-level controller.

Parameters:
- row, 8, number of array rows (instruction lanes).
- col, 8, number of array columns; sets WS kernel-load length and drain length.
- cnt_bw, 16, width of the vector-count operand and internal counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = WS, 1 = OS; captured with start.
- num_vec  input  cnt_bw  number of execute/accumulate vectors; captured with start.
- inst_w  output  3*row  per-row instruction; lane r occupies bits [3r+2:3r].
- buf_rd  output  1  input-buffer pop; high on every cycle row-0 consumes data.
- busy  output  1  high while not IDLE.
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset: FSM to IDLE; all outputs 0; stagger shift registers cleared; captured mode/num_vec cleared. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, LOAD, GAP, EXEC, DRAIN, DONE. Base instruction base[2:0] drives lane 0; lane r = base registered r times.
- IDLE: base = 0. On start=1, capture mode and num_vec.
  - Next state is LOAD if mode=0, else EXEC.
  - If num_vec=0 and mode=1, next state is DRAIN.
- LOAD (WS only): col cycles; base = 3'b001; buf_rd = 1. Then go to GAP.
- GAP: 1 cycle; base = 3'b000. Then go to EXEC, or DRAIN if num_vec=0.
- EXEC: num_vec cycles; buf_rd = 1. Then go to DRAIN.
  - WS: base = 3'b010.
  - OS: base = 3'b101.
- DRAIN: row+col-1 cycles; buf_rd = 0. Then go to DONE.
  - WS: base = 3'b000 (pipeline flush).
  - OS: base = 3'b110 (pass_psum).
- DONE: 1 cycle; done = 1; base = 0 (bit2 = mode). Then go to IDLE.
- busy is 1 in every state except IDLE, so it rises the cycle after start is accepted.
- base[2] equals the captured mode in all non-IDLE states.
- start while busy is ignored; no queueing.
- The state counter loads terminal-1 on entry and advances on reaching 0. Comparisons use cnt_bw bits; num_vec = 2^cnt_bw-1 is legal.
- Stagger registers keep shifting in IDLE (shifting in 0), so trailing lanes finish their wavefront after done.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- When defined: adds input abort (1 bit). abort=1 in LOAD, GAP or EXEC forces DRAIN on the next cycle with base = 3'b000 regardless of mode, then DONE with done pulse. abort in IDLE, DRAIN or DONE is ignored.
- When undefined: no abort port; FSM as above.

Test Plan (row=4, col=4):
- WS, num_vec=3, start at cycle 0 -> lane0 inst_w:
  - cycles 1-4 = 001;
  - cycle 5 = 000;
  - cycles 6-8 = 010;
  - cycles 9-15 = 000;
  - done=1 at cycle 16; busy=1 cycles 1-16; buf_rd high on cycles 1-4 and 6-8.
- OS, num_vec=2, start at cycle 0 -> lane0 inst_w:
  - cycles 1-2 = 101;
  - cycles 3-9 = 110;
  - cycle 10 = 100 with done=1.
- Stagger check, WS run above -> lane3 equals lane0 delayed 3 cycles; lane3 first shows 001 at cycle 4 and last shows 010 at cycle 11.
- start=1 at cycle 3 during a busy WS run -> no effect; done pulses exactly once at cycle 16. OS with num_vec=0 -> DRAIN cycles 1-7, done at cycle 8.
- reset asserted at cycle 6 of the WS run -> cycle 7 shows all inst_w = 0, busy = 0, done never pulses; a new start is accepted at cycle 8.
- SEQ_ABORT_EN, WS run with abort at cycle 6 -> base = 000 cycles 7-13, done at cycle 14.
